// File: rtl/tm_sched_pkg.sv
// rtl/tm_sched_pkg.sv - shared types and truncated-multiply helpers for tm_mult_sched
package tm_sched_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Largest truncation depth for the default 8-bit operand width.
    localparam int K_MAX = 8;
    // Widest operand the helpers handle; callers zero-extend into this width.
    localparam int MAX_W = 16;

    // Mask that clears the k least-significant operand bits.
    function automatic logic [MAX_W-1:0] trunc_mask(input logic [3:0] k);
        return ~((MAX_W'(1) << k) - MAX_W'(1));
    endfunction

    // Unsigned product of the two truncated operands, full double width.
    function automatic logic [2*MAX_W-1:0] tm_product(input logic [MAX_W-1:0] a,
                                                      input logic [MAX_W-1:0] b,
                                                      input logic [3:0]       k);
        logic [2*MAX_W-1:0] ea;
        logic [2*MAX_W-1:0] eb;
        ea = {{MAX_W{1'b0}}, a & trunc_mask(k)};
        eb = {{MAX_W{1'b0}}, b & trunc_mask(k)};
        return ea * eb;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner search starting after ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDW-1:0]     i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDW-1:0]     o_grant_id
);

    logic w_found;
    int   w_idx;

    // Pick the first requester with req set, scanning circularly from ptr+1.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = (int'(i_ptr) + i) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_id     = IDW'(w_idx);
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tm_mult_sched.sv
// rtl/tm_mult_sched.sv - round-robin scheduler in front of a 2-stage truncated multiplier
module tm_mult_sched
    import tm_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int W         = 8,
    parameter int K_DEFAULT = 4,
    parameter int IDW       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [2*W-1:0]       resp_p,
    input  logic                 cfg_valid,
    input  logic [3:0]           cfg_k,
    output logic                 cfg_ack,
    output logic                 busy,
    output logic [15:0]          op_count
);

    state_t               r_state;
    logic [3:0]           r_k;
    logic [3:0]           r_k_pend;
    logic [IDW-1:0]       r_ptr;
    logic                 r_s1_v;
    logic [W-1:0]         r_s1_a;
    logic [W-1:0]         r_s1_b;
    logic [IDW-1:0]       r_s1_id;
    logic [3:0]           r_s1_k;
    logic                 r_s2_v;
    logic [2*W-1:0]       r_s2_p;
    logic [IDW-1:0]       r_s2_id;
    logic [15:0]          r_op_count;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDW-1:0]       w_grant_id;
    logic                 w_s2_load;
    logic                 w_s1_can;
    logic                 w_grant_en;
    logic                 w_xfer;
    logic                 w_empty;
    logic [3:0]           w_k_clamped;
    logic [2*W-1:0]       w_prod;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .i_req      (req_valid),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    // S2 takes whatever S1 holds (op or bubble) whenever its slot frees up.
    assign w_s2_load   = !r_s2_v || resp_ready;
    assign w_s1_can    = !r_s1_v || w_s2_load;
    assign w_grant_en  = (r_state == RUN) && w_s1_can;
    assign req_ready   = (rst_n && w_grant_en) ? w_grant : '0;
    assign w_xfer      = |(req_valid & req_ready);
    assign w_empty     = !r_s1_v && !r_s2_v;
    assign w_k_clamped = (cfg_k > 4'(W)) ? 4'(W) : cfg_k;
    assign w_prod      = (2*W)'(tm_product(MAX_W'(r_s1_a), MAX_W'(r_s1_b), r_s1_k));

    assign resp_valid  = r_s2_v;
    assign resp_p      = r_s2_p;
    assign resp_id     = r_s2_id;
    assign busy        = (r_state == DRAIN);
    assign cfg_ack     = (r_state == DRAIN) && w_empty;
    assign op_count    = r_op_count;

    // Operand capture and product stages; k is frozen into the op at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v  <= 1'b0;
            r_s1_a  <= '0;
            r_s1_b  <= '0;
            r_s1_id <= '0;
            r_s1_k  <= 4'(K_DEFAULT);
            r_s2_v  <= 1'b0;
            r_s2_p  <= '0;
            r_s2_id <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_v  <= r_s1_v;
                r_s2_p  <= w_prod;
                r_s2_id <= r_s1_id;
            end
            if (w_s1_can) begin
                r_s1_v <= w_xfer;
                if (w_xfer) begin
                    r_s1_a  <= req_a[int'(w_grant_id)*W +: W];
                    r_s1_b  <= req_b[int'(w_grant_id)*W +: W];
                    r_s1_id <= w_grant_id;
                    r_s1_k  <= r_k;
                end
            end
        end
    end

    // Round-robin pointer follows the last winner that actually transferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IDW'(NUM_REQ-1);
        end else if (w_xfer) begin
            r_ptr <= w_grant_id;
        end
    end

    // Count consumed responses, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (r_s2_v && resp_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    // Config FSM: stop granting, wait for both stages to empty, then swap k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_k      <= 4'(K_DEFAULT);
            r_k_pend <= 4'(K_DEFAULT);
        end else begin
            case (r_state)
                RUN: begin
                    if (cfg_valid) begin
                        r_k_pend <= w_k_clamped;
                        r_state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_k     <= r_k_pend;
                        r_state <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_tm_mult_sched.sv
// tb/tb_tm_mult_sched.sv - randomized and directed self-checking bench for tm_mult_sched
module tb_tm_mult_sched;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [1:0]  resp_id;
    logic [15:0] resp_p;
    logic        cfg_valid = 1'b0;
    logic [3:0]  cfg_k = '0;
    logic        cfg_ack;
    logic        busy;
    logic [15:0] op_count;

    tm_mult_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .cfg_valid  (cfg_valid),
        .cfg_k      (cfg_k),
        .cfg_ack    (cfg_ack),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: a pool of at most two in-flight ops, FIFO order.
    int          m_ptr;
    int          m_k;
    int          m_kpend;
    bit          m_drain;
    int          m_inflight;
    logic [15:0] m_count;
    logic [15:0] sb_p[$];
    int          sb_id[$];
    bit          prev_hold;
    logic [15:0] prev_p;
    logic [1:0]  prev_id;
    logic [3:0]  g_dut;

    function automatic logic [15:0] ref_prod(input int a, input int b, input int k);
        int ta;
        int tb;
        ta = (a >> k) << k;
        tb = (b >> k) << k;
        return 16'(ta * tb);
    endfunction

    task automatic model_reset();
        m_ptr      = N - 1;
        m_k        = 4;
        m_kpend    = 4;
        m_drain    = 1'b0;
        m_inflight = 0;
        m_count    = '0;
        sb_p.delete();
        sb_id.delete();
        prev_hold  = 1'b0;
    endtask

    // One clock: check at negedge, advance the model, return just after posedge.
    task automatic step();
        bit          allowed;
        int          win;
        logic [3:0]  exp_ready;
        bit          hs;
        bit          xfer;
        @(negedge clk);
        allowed = !m_drain && !(m_inflight == 2 && !resp_ready);
        win = -1;
        for (int i = 1; i <= N; i++) begin
            if (win < 0 && req_valid[(m_ptr + i) % N]) win = (m_ptr + i) % N;
        end
        exp_ready = '0;
        if (allowed && win >= 0) exp_ready[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("busy", 32'(busy), 32'(m_drain));
        chk("cfg_ack", 32'(cfg_ack), 32'(m_drain && m_inflight == 0));
        chk("op_count", 32'(op_count), 32'(m_count));
        if (m_inflight == 0) chk("resp_valid_idle", 32'(resp_valid), 32'd0);
        if (m_inflight == 2) chk("resp_valid_full", 32'(resp_valid), 32'd1);
        if (prev_hold) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_p", 32'(resp_p), 32'(prev_p));
            chk("hold_id", 32'(resp_id), 32'(prev_id));
        end
        g_dut = req_ready & req_valid;
        hs = resp_valid && resp_ready;
        if (hs) begin
            if (sb_p.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                chk("resp_id", 32'(resp_id), 32'(sb_id.pop_front()));
                chk("resp_p", 32'(resp_p), 32'(sb_p.pop_front()));
            end
        end
        xfer = (exp_ready & req_valid) != 0;
        if (xfer) begin
            sb_id.push_back(win);
            sb_p.push_back(ref_prod(int'(req_a[win*8 +: 8]), int'(req_b[win*8 +: 8]), m_k));
            m_ptr = win;
        end
        prev_hold = resp_valid && !resp_ready;
        prev_p    = resp_p;
        prev_id   = resp_id;
        if (m_drain) begin
            if (m_inflight == 0) begin
                m_k     = m_kpend;
                m_drain = 1'b0;
            end
        end else if (cfg_valid) begin
            m_kpend = (cfg_k > 8) ? 8 : int'(cfg_k);
            m_drain = 1'b1;
        end
        m_inflight = m_inflight + int'(xfer) - int'(hs);
        if (hs) m_count = m_count + 16'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        cfg_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic issue(input int id, input logic [7:0] a, input logic [7:0] b);
        bit done;
        done = 1'b0;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_a[id*8 +: 8] = a;
        req_b[id*8 +: 8] = b;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (g_dut[id]) done = 1'b1;
        end
        if (!done) chk("issue_timeout", 32'd0, 32'd1);
        req_valid = '0;
    endtask

    task automatic wait_resp(output logic [15:0] p, output logic [1:0] id);
        bit done;
        done = 1'b0;
        p = '0;
        id = '0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (resp_valid && resp_ready) begin
                p = resp_p;
                id = resp_id;
                done = 1'b1;
            end
            step();
        end
        if (!done) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic set_k(input logic [3:0] k);
        cfg_valid = 1'b1;
        cfg_k = k;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 20 && m_drain; i++) step();
    endtask

    logic [15:0] p;
    logic [1:0]  id;
    int          acc;
    int          gid;

    initial begin
        model_reset();
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_p", 32'(resp_p), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cfg_ack", 32'(cfg_ack), 32'd0);
        do_reset();

        // Default k=4, latency of two cycles.
        resp_ready = 1'b1;
        issue(0, 8'hFF, 8'hFF);
        chk("lat_t1_valid", 32'(resp_valid), 32'd0);
        step();
        chk("lat_t2_valid", 32'(resp_valid), 32'd1);
        chk("lat_t2_p", 32'(resp_p), 32'hE100);
        chk("lat_t2_id", 32'(resp_id), 32'd0);
        step();
        chk("op_count_one", 32'(op_count), 32'd1);

        // k=0 from an empty pipe: one-cycle drain, ack the cycle after cfg_valid.
        cfg_valid = 1'b1;
        cfg_k = 4'd0;
        step();
        cfg_valid = 1'b0;
        chk("cfg0_busy", 32'(busy), 32'd1);
        chk("cfg0_ack", 32'(cfg_ack), 32'd1);
        step();
        chk("cfg0_busy_done", 32'(busy), 32'd0);
        chk("cfg0_ack_done", 32'(cfg_ack), 32'd0);
        issue(0, 8'hFF, 8'hFF);
        wait_resp(p, id);
        chk("k0_exact", 32'(p), 32'hFE01);
        set_k(4'd12);
        issue(2, 8'hFF, 8'hFF);
        wait_resp(p, id);
        chk("k_clamped", 32'(p), 32'h0000);

        // All requesters continuously valid: strict rotation from requester 0.
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < 12; i++) begin
            req_a = $urandom;
            req_b = $urandom;
            step();
            gid = -1;
            for (int j = 0; j < N; j++) if (g_dut[j]) gid = j;
            chk("rr_order", 32'(gid), 32'(i % N));
        end
        req_valid = '0;
        for (int i = 0; i < 4; i++) step();

        // Backpressure: three requesters, consumer stalled for five cycles.
        resp_ready = 1'b0;
        req_valid = 4'b0111;
        req_a = $urandom;
        req_b = $urandom;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            acc += $countones(g_dut);
            req_valid = req_valid & ~g_dut;
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && (req_valid != 0 || m_inflight != 0); i++) begin
            step();
            req_valid = req_valid & ~g_dut;
        end
        chk("bp_all_done", 32'(sb_p.size()), 32'd0);

        // Reconfigure with two ops stalled: old k applies, ack waits for drain.
        do_reset();
        resp_ready = 1'b0;
        issue(1, 8'h34, 8'h27);
        issue(2, 8'h12, 8'h9A);
        cfg_valid = 1'b1;
        cfg_k = 4'd2;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_busy", 32'(busy), 32'd1);
            chk("drain_no_ack", 32'(cfg_ack), 32'd0);
        end
        resp_ready = 1'b1;
        wait_resp(p, id);
        chk("old_k_p", 32'(p), 32'h0600);
        chk("old_k_id", 32'(id), 32'd1);
        for (int i = 0; i < 4; i++) step();

        // Asynchronous reset in the middle of a drain with ops in flight.
        resp_ready = 1'b0;
        issue(0, 8'hAB, 8'hCD);
        issue(3, 8'h11, 8'h22);
        cfg_valid = 1'b1;
        cfg_k = 4'd1;
        step();
        cfg_valid = 1'b0;
        step();
        req_valid = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_resp_p", 32'(resp_p), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_op_count", 32'(op_count), 32'd0);
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        issue(0, 8'hFF, 8'hFF);
        wait_resp(p, id);
        chk("arst_k_default", 32'(p), 32'hE100);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            req_valid  = 4'($urandom_range(0, 15));
            req_a      = $urandom;
            req_b      = $urandom;
            resp_ready = ($urandom_range(0, 9) < 7);
            cfg_valid  = ($urandom_range(0, 31) == 0);
            cfg_k      = 4'($urandom_range(0, 15));
            step();
        end
        req_valid  = '0;
        cfg_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("final_sb_empty", 32'(sb_p.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tm_mult_sched.md
Name: tm_mult_sched

Overview:
- Schedules one shared truncated-multiplier (TM) datapath among NUM_REQ requesters using round-robin arbitration.
- Two-stage registered pipeline: operand capture, then product.
- Truncation depth k is runtime-configurable through a drain-then-apply config handshake.
- Sits between accelerator clients and the approximate-multiplier datapath; lets one TM instance serve several issuing units.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 8, operand width; product width 2*W.
- K_DEFAULT, 4, truncation depth loaded at reset.
- IDW, 2, requester-id width = clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ*W  packed operand A, requester i at [i*W +: W].
- req_b  in  NUM_REQ*W  packed operand B.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- resp_valid  out  1  product valid.
- resp_ready  in  1  consumer ready.
- resp_id  out  IDW  requester that issued the product.
- resp_p  out  2*W  truncated product.
- cfg_valid  in  1  new truncation depth request.
- cfg_k  in  4  requested k; values above W are clamped to W.
- cfg_ack  out  1  one-cycle pulse when the new k becomes active.
- busy  out  1  high in DRAIN state.
- op_count  out  16  completed responses, wraps at 0xFFFF->0.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - req_ready=0, resp_valid=0, resp_id=0, resp_p=0.
  - cfg_ack=0, busy=0, op_count=0.
  - Active k=K_DEFAULT, RR pointer=NUM_REQ-1 (requester 0 wins first), FSM=RUN, both pipeline stages empty.
- Reset mid-operation: in-flight operations are discarded. No response is emitted after reset for them.
- Product: resp_p = (a & ~((1<<k)-1)) * (b & ~((1<<k)-1)), full 2*W bits, unsigned.
  - k=0 gives the exact product.
  - k=W gives 0.
- Pipeline:
  - S1 holds {a,b,id,v}; S2 holds {p,id,v}.
  - S2 loads when !S2.v or resp_ready.
  - S1 advances when S2 loads.
  - S1 may accept when !S1.v or S1 advances.
  - Latency: accepted at cycle t -> resp_valid at t+2 when there is no backpressure. Throughput is 1 op/cycle.
- Backpressure: while resp_valid & !resp_ready, resp_p and resp_id hold stable. Nothing is dropped or duplicated.
- Arbitration:
  - Combinational grant in RUN when S1 can accept.
  - Winner = first requester with req_valid set, searching circularly from ptr+1.
  - req_ready is one-hot to the winner and never asserted to a requester with req_valid low.
  - ptr updates to the winner only on a transfer.
  - No grants in DRAIN.
- FSM:
  - RUN: cfg_valid=1 -> latch clamped cfg_k into k_pend, go to DRAIN. The op granted in that same cycle is still accepted.
  - DRAIN: busy=1, no grants, cfg_valid ignored.
    - When S1.v=0 and S2.v=0, apply k=k_pend, pulse cfg_ack, return to RUN.
    - Drain completes only after resp_ready has consumed all pending results.
  - cfg_valid while already empty: DRAIN lasts 1 cycle; cfg_ack fires the cycle after cfg_valid.
- k sampling: k is read when an op enters S1. Ops in flight never see a k change.
- op_count: increments on each resp_valid & resp_ready.

Decomposition:
- Package tm_sched_pkg:
  - state enum {RUN, DRAIN}.
  - K_MAX=W.
  - function trunc_mask(k).
  - function tm_product(a,b,k).
- One sub-module, rr_arbiter (NUM_REQ): req vector, ptr, grant one-hot, and encoded winner id.

Test Plan:
- Reset, k=4, req0 a=0xFF b=0xFF, resp_ready=1 -> resp_valid two cycles after the transfer, resp_p=0xE100, resp_id=0, op_count=1.
- cfg k=0, then the same operands -> busy pulses, cfg_ack=1 once, resp_p=0xFE01. Next, cfg_k=12 -> clamped to 8, product of 0xFF*0xFF = 0x0000.
- All 4 requesters hold valid continuously -> grant order 0,1,2,3,0,... with one grant per cycle and resp_id following the same sequence.
- resp_ready held low 5 cycles with 3 ops issued -> at most 2 accepted. resp_p/resp_id stay stable, no grants while both stages are full. On release, the 3rd request is granted and all 3 results arrive in order.
- cfg_valid asserted with 2 ops in flight and resp_ready low -> stays in DRAIN until both results are consumed. In-flight products use the old k=4 (0x34*0x27 -> 0x30*0x20=0x0600). cfg_ack only after S2 empties.
- rst_n dropped asynchronously mid-drain with ops in flight -> outputs immediately 0, k=K_DEFAULT, FSM=RUN. No stale resp_valid after reset release.
